// File: rtl/lif_pkg.sv
// Shared types, defaults and saturating helper for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } lif_state_e;

    localparam int DEF_THRESH      = 200;
    localparam int DEF_DECAY_SHIFT = 3;

    // Unsigned add clamped at max_v; the 33-bit sum cannot wrap for any W up to 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[31:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leaky-integrate-and-fire step: leak, add current, saturate, threshold compare.
module lif_update
    import lif_pkg::*;
#(
    parameter int W           = 8,
    parameter int THRESH      = DEF_THRESH,
    parameter int DECAY_SHIFT = DEF_DECAY_SHIFT
) (
    input  logic [W-1:0] v,
    input  logic [W-1:0] acc,
    output logic [W-1:0] v_next,
    output logic         fire
);

    localparam logic [31:0]  SAT_MAX = 32'((64'd1 << W) - 64'd1);
    localparam logic [W-1:0] THR     = W'(THRESH);

    logic [W-1:0] leaked;
    logic [W-1:0] u;

    assign leaked = v - (v >> DECAY_SHIFT);
    assign u      = W'(sat_add(32'(leaked), 32'(acc), SAT_MAX));
    assign fire   = (u >= THR);
    assign v_next = fire ? (u - THR) : u;

endmodule

// File: rtl/lif_scheduler.sv
// Shares one lif_update datapath across N virtual neurons: accumulates currents while idle,
// scans all neurons on tick and emits one spike event per firing neuron over valid/ready.
//
// state | meaning
// IDLE  | accept currents into acc, wait for tick
// SCAN  | update neuron idx, clear its acc
// EMIT  | hold spike_id until spike_ready
// DONE  | one-cycle end-of-timestep pulse
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int THRESH      = DEF_THRESH,
    parameter int DECAY_SHIFT = DEF_DECAY_SHIFT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 cur_valid,
    output logic                 cur_ready,
    input  logic [$clog2(N)-1:0] cur_id,
    input  logic [W-1:0]         cur_data,
    output logic                 spike_valid,
    input  logic                 spike_ready,
    output logic [$clog2(N)-1:0] spike_id,
    output logic                 busy,
    output logic                 done,
    input  logic [$clog2(N)-1:0] state_sel,
    output logic [W-1:0]         state_out
);

    localparam int          IW      = $clog2(N);
    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [31:0] SAT_MAX = 32'((64'd1 << W) - 64'd1);

    lif_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] spike_id_q, spike_id_d;
    logic [W-1:0]  v_q   [N];
    logic [W-1:0]  v_d   [N];
    logic [W-1:0]  acc_q [N];
    logic [W-1:0]  acc_d [N];

    logic [W-1:0]  upd_v;
    logic          upd_fire;

    lif_update #(
        .W           (W),
        .THRESH      (THRESH),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_update (
        .v      (v_q[idx_q]),
        .acc    (acc_q[idx_q]),
        .v_next (upd_v),
        .fire   (upd_fire)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        spike_id_d = spike_id_q;
        v_d        = v_q;
        acc_d      = acc_q;
        unique case (state_q)
            IDLE: begin
                // Current lands in acc on the same edge as tick, so this timestep sees it.
                if (cur_valid) begin
                    acc_d[cur_id] = W'(sat_add(32'(acc_q[cur_id]), 32'(cur_data), SAT_MAX));
                end
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                acc_d[idx_q] = '0;
                v_d[idx_q]   = upd_v;
                if (upd_fire) begin
                    spike_id_d = idx_q;
                    state_d    = EMIT;
                end else if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            EMIT: begin
                if (spike_ready) begin
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            spike_id_q <= '0;
            v_q        <= '{default: '0};
            acc_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            spike_id_q <= spike_id_d;
            v_q        <= v_d;
            acc_q      <= acc_d;
        end
    end

    assign cur_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign spike_valid = (state_q == EMIT);
    assign spike_id    = spike_id_q;
    assign state_out   = v_q[state_sel];

endmodule

// File: tb/tb_lif_scheduler.sv
// Scoreboard bench for lif_scheduler: a reference LIF model predicts spikes and membranes per timestep.
module tb_lif_scheduler;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       cur_valid;
    logic       cur_ready;
    logic [1:0] cur_id;
    logic [7:0] cur_data;
    logic       spike_valid;
    logic       spike_ready;
    logic [1:0] spike_id;
    logic       busy;
    logic       done;
    logic [1:0] state_sel;
    logic [7:0] state_out;

    int checks;
    int errors;
    int nspk;
    int sb[$];
    int v_m[4];
    int acc_m[4];

    lif_scheduler #(
        .N           (4),
        .W           (8),
        .THRESH      (200),
        .DECAY_SHIFT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .cur_valid   (cur_valid),
        .cur_ready   (cur_ready),
        .cur_id      (cur_id),
        .cur_data    (cur_data),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spike_id    (spike_id),
        .busy        (busy),
        .done        (done),
        .state_sel   (state_sel),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reference model: one timestep over all neurons, spikes pushed in index order.
    task automatic predict();
        for (int i = 0; i < 4; i++) begin
            int s;
            s = v_m[i] - (v_m[i] / 8) + acc_m[i];
            if (s > 255) s = 255;
            if (s >= 200) begin
                sb.push_back(i);
                v_m[i] = s - 200;
            end else begin
                v_m[i] = s;
            end
            acc_m[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cur(input int id, input int data);
        int n;
        cur_valid = 1'b1;
        cur_id    = 2'(id);
        cur_data  = 8'(data);
        n = 0;
        while (!cur_ready && n < 100) begin
            step();
            n++;
        end
        check("cur_accept_wait", int'(cur_ready), 1);
        acc_m[id] = (acc_m[id] + data > 255) ? 255 : acc_m[id] + data;
        step();
        cur_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        predict();
        step();
        tick = 1'b0;
    endtask

    task automatic do_cur_tick(input int id, input int data);
        cur_valid = 1'b1;
        cur_id    = 2'(id);
        cur_data  = 8'(data);
        tick      = 1'b1;
        acc_m[id] = (acc_m[id] + data > 255) ? 255 : acc_m[id] + data;
        predict();
        step();
        cur_valid = 1'b0;
        tick      = 1'b0;
    endtask

    task automatic run_step(input int stall, input bit noise, input bit late_cur,
                            input int lc_id, input int lc_data, input int watch_v,
                            output int cyc);
        int sc;
        sc  = 0;
        cyc = 1;
        check("busy_after_tick", int'(busy), 1);
        while (!done && cyc < 200) begin
            tick = noise && (cyc == 2);
            if (late_cur && cyc == 1) begin
                cur_valid = 1'b1;
                cur_id    = 2'(lc_id);
                cur_data  = 8'(lc_data);
            end
            if (cyc == 2) check("cur_ready_busy", int'(cur_ready), 0);
            if (spike_valid) begin
                if (sc < stall) begin
                    spike_ready = 1'b0;
                    sc++;
                    if (sb.size() > 0) begin
                        check("stall_id", int'(spike_id), sb[0]);
                        if (sb[0] == 1) check("stall_hold_n2", int'(state_out), watch_v);
                    end
                end else begin
                    spike_ready = 1'b1;
                    sc = 0;
                    nspk++;
                    if (sb.size() == 0) check("unexpected_spike", 1, 0);
                    else check("spike_id", int'(spike_id), sb.pop_front());
                end
            end else begin
                spike_ready = 1'b0;
            end
            step();
            cyc++;
        end
        tick        = 1'b0;
        spike_ready = 1'b0;
        check("done_seen", int'(done), 1);
        check("cur_ready_in_done", int'(cur_ready), 0);
        check("sb_empty", sb.size(), 0);
        step();
        check("done_pulse_len", int'(done), 0);
        check("cur_ready_after", int'(cur_ready), 1);
    endtask

    task automatic check_v(input string tag);
        for (int i = 0; i < 4; i++) begin
            state_sel = 2'(i);
            #1;
            check(tag, int'(state_out), v_m[i]);
        end
    endtask

    initial begin
        int cyc;
        int n;
        checks = 0; errors = 0; nspk = 0;
        rst = 1'b1; tick = 1'b0; cur_valid = 1'b0; cur_id = '0; cur_data = '0;
        spike_ready = 1'b0; state_sel = '0;
        for (int i = 0; i < 4; i++) begin v_m[i] = 0; acc_m[i] = 0; end
        repeat (3) step();
        check("rst_spike_valid", int'(spike_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_spike_id", int'(spike_id), 0);
        rst = 1'b0;
        step();
        check("idle_cur_ready", int'(cur_ready), 1);
        check_v("rst_v");

        // Basic integration: no spike, then a spike on neuron 0.
        do_cur(0, 100);
        do_tick();
        run_step(0, 0, 0, 0, 0, 0, cyc);
        check("basic_cycles", cyc, 5);
        check_v("basic_v");
        do_cur(0, 120);
        do_tick();
        run_step(0, 0, 0, 0, 0, 0, cyc);
        check("spike0_cycles", cyc, 6);
        check("v0_after_fire", v_m[0], 8);
        check_v("spike0_v");

        // Saturating accumulation on neuron 2.
        do_cur(2, 200);
        do_cur(2, 200);
        do_tick();
        run_step(0, 0, 0, 0, 0, 0, cyc);
        check("sat_cycles", cyc, 6);
        check("v2_after_sat", v_m[2], 55);
        check_v("sat_v");

        // Backpressure: neurons 1 and 3 fire, consumer stalls 5 cycles on each.
        do_cur(1, 220);
        do_cur(3, 230);
        state_sel = 2'd2;
        n = v_m[2];
        nspk = 0;
        do_tick();
        run_step(5, 0, 0, 0, 0, n, cyc);
        check("bp_spikes", nspk, 2);
        check("bp_cycles", cyc, 5 + 2 * 6);
        check_v("bp_v");

        // Tick during scan is ignored; current offered while busy waits for IDLE.
        do_tick();
        run_step(0, 1, 1, 0, 50, 0, cyc);
        check("noise_cycles", cyc, 5);
        check("late_cur_ready", int'(cur_ready), 1);
        acc_m[0] = acc_m[0] + 50;
        step();
        cur_valid = 1'b0;
        check("no_rescan", int'(busy), 0);
        step();
        check("no_rescan2", int'(busy), 0);
        check_v("noise_v");

        // Current and tick on the same edge: neuron 1 fires this timestep.
        nspk = 0;
        do_cur_tick(1, 250);
        check("same_edge_pred", sb.size() > 0 ? sb[0] : -1, 1);
        run_step(0, 0, 0, 0, 0, 0, cyc);
        check("same_edge_spikes", nspk, 1);
        check_v("same_edge_v");

        // Reset while a spike is pending; pending acc on neuron 3 must be lost.
        do_cur(0, 210);
        do_cur(3, 50);
        do_tick();
        n = 0;
        while (!spike_valid && n < 50) begin
            step();
            n++;
        end
        check("emit_reached", int'(spike_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", int'(spike_valid), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_id", int'(spike_id), 0);
        sb.delete();
        for (int i = 0; i < 4; i++) begin v_m[i] = 0; acc_m[i] = 0; end
        check_v("rst_mid_v");
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", int'(busy), 0);
        check("post_rst_ready", int'(cur_ready), 1);
        do_cur(0, 10);
        do_tick();
        run_step(0, 0, 0, 0, 0, 0, cyc);
        check("post_rst_cycles", cyc, 5);
        check_v("post_rst_v");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
